// File: rtl/quad_control_gen_if.sv
// Signal bundle between a quadrature encoder front end and quad_control_gen.
// The master drives the raw encoder and request lines; the slave (the generator) returns control/error.
interface quad_control_gen_if;
   logic       quad_a;
   logic       quad_b;
   logic       index;
   logic       enable;
   logic       clear_req;
   logic [1:0] control;
   logic       error;

   modport master (
      output quad_a, quad_b, index, enable, clear_req,
      input  control, error
   );

   modport slave (
      input  quad_a, quad_b, index, enable, clear_req,
      output control, error
   );
endinterface

// File: rtl/quad_control_gen.sv
// Quadrature decoder: synchronise, debounce and Gray-decode A/B into up/down/hold/reset counter commands.
// Optional INDEX_CLEAR_EN: a synchronised rising edge on index acts as a one-cycle clear_req.
module quad_control_gen #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   quad_control_gen_if.slave bus
);

   typedef enum logic [1:0] {
      CTRL_RESET = 2'b00,
      CTRL_UP    = 2'b01,
      CTRL_HOLD  = 2'b10,
      CTRL_DOWN  = 2'b11
   } ctrl_e;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DOWN,
      STEP_ILLEGAL
   } step_e;

   localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("quad_control_gen: SYNC_STAGES must be 2..4");
      end
      if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
         $error("quad_control_gen: DEBOUNCE_CYCLES must be 1..255");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_a;
   logic [SYNC_STAGES-1:0] sync_b;
   logic [1:0]             synced_ab;
   logic [1:0]             filt_ab;
   logic [1:0][7:0]        deb_cnt;
   logic [1:0]             prev_ab;
   step_e                  step;
   logic                   index_clear;
   logic                   clear_any;
   ctrl_e                  control_q;
   ctrl_e                  control_d;
   logic                   error_q;
   logic                   error_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
   // reset is synchronous, so it is just the highest-priority branch of the clocked block.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[SYNC_STAGES-2:0], bus.quad_a};
         sync_b <= {sync_b[SYNC_STAGES-2:0], bus.quad_b};
      end
   end

   assign synced_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

   // A filtered bit flips only after the synced value has disagreed for DEBOUNCE_CYCLES+1 edges.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         filt_ab <= '0;
         deb_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (synced_ab[i] == filt_ab[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LIMIT) begin
               filt_ab[i] <= synced_ab[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 8'd1;
            end
         end
      end
   end

`ifdef INDEX_CLEAR_EN
   // Two extra stages past the synchroniser: the edge is taken between them, giving SYNC_STAGES+1 latency.
   logic [SYNC_STAGES+1:0] sync_idx;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync_idx <= '0;
      end else begin
         sync_idx <= {sync_idx[SYNC_STAGES:0], bus.index};
      end
   end

   assign index_clear = sync_idx[SYNC_STAGES] & ~sync_idx[SYNC_STAGES+1];
`else
   logic index_unused;

   assign index_unused = bus.index;
   assign index_clear  = 1'b0;
`endif

   // Gray order 00 -> 01 -> 11 -> 10 -> 00 is forward; both bits changing is illegal.
   always_comb begin
      // NOTE: default first so every path assigns step and no latch is inferred.
      step = STEP_NONE;
      unique case ({prev_ab, filt_ab})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_UP;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_DOWN;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = STEP_ILLEGAL;
         default:                                step = STEP_NONE;
      endcase
   end

   assign clear_any = bus.clear_req | index_clear;

   always_comb begin
      control_d = CTRL_HOLD;
      error_d   = error_q;

      if (clear_any) begin
         control_d = CTRL_RESET;
      end else if (bus.enable && step == STEP_UP) begin
         control_d = CTRL_UP;
      end else if (bus.enable && step == STEP_DOWN) begin
         control_d = CTRL_DOWN;
      end

      // A double change seen in the same cycle as a clear still latches the error.
      if (step == STEP_ILLEGAL) begin
         error_d = 1'b1;
      end else if (clear_any) begin
         error_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         prev_ab   <= '0;
         control_q <= CTRL_RESET;
         error_q   <= 1'b0;
      end else begin
         prev_ab   <= filt_ab;
         control_q <= control_d;
         error_q   <= error_d;
      end
   end

   assign bus.control = control_q;
   assign bus.error   = error_q;

endmodule

// File: tb/tb_quad_control_gen.sv
// Scoreboard bench for quad_control_gen: a history-based reference model predicts control/error per edge.
// Build with +define+INDEX_CLEAR_EN to exercise the index-clear feature.
module tb_quad_control_gen;

   localparam int S    = 2;
   localparam int D    = 4;
   localparam int MAXC = 4096;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   quad_control_gen_if bus ();

   quad_control_gen #(
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0] control;
      logic       error;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   started  = 0;

   // Input history, indexed by the clock edge at which each value is sampled.
   bit h_rst[MAXC];
   bit h_a[MAXC];
   bit h_b[MAXC];
   bit h_i[MAXC];
   bit h_en[MAXC];
   bit h_clr[MAXC];
   int k = 0;

   // Reference model state.
   bit [1:0] m_filt;
   int       m_run[2];
   bit [1:0] m_prev;
   bit       m_err;

   bit cur_a, cur_b, cur_en, cur_idx;

   task automatic check(input string name, input int edge_no, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
      end
   endtask

   // Value of a raw input seen through a reset-clearable chain of 'lag' flops at edge kk.
   function automatic bit seen(input int ch, input int kk, input int lag);
      if (kk - lag < 0) return 1'b0;
      for (int j = kk - lag; j < kk; j++) begin
         if (h_rst[j]) return 1'b0;
      end
      case (ch)
         0:       return h_a[kk-lag];
         1:       return h_b[kk-lag];
         default: return h_i[kk-lag];
      endcase
   endfunction

   function automatic int gray_pos(input bit [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic bit [1:0] gray_ab(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_step(input int kk);
      exp_t e;
      int   delta;
      bit   clr;
      bit   s;
      if (h_rst[kk]) begin
         m_filt = 2'b00;
         m_run  = '{0, 0};
         m_prev = 2'b00;
         m_err  = 1'b0;
         e      = '{control: 2'b00, error: 1'b0};
      end else begin
         delta = (gray_pos(m_filt) - gray_pos(m_prev) + 4) % 4;
         clr   = h_clr[kk];
`ifdef INDEX_CLEAR_EN
         clr   = clr | (seen(2, kk, S + 1) & ~seen(2, kk, S + 2));
`endif
         if (clr)                         e.control = 2'b00;
         else if (h_en[kk] && delta == 1) e.control = 2'b01;
         else if (h_en[kk] && delta == 3) e.control = 2'b11;
         else                             e.control = 2'b10;
         if (delta == 2)  m_err = 1'b1;
         else if (clr)    m_err = 1'b0;
         e.error = m_err;
         m_prev  = m_filt;
         // Each channel's filtered value adopts the synced one after D+1 consecutive disagreeing edges.
         for (int ch = 0; ch < 2; ch++) begin
            s = seen(ch, kk, S);
            if (s != m_filt[1-ch]) begin
               m_run[ch]++;
               if (m_run[ch] == D + 1) begin
                  m_filt[1-ch] = s;
                  m_run[ch]    = 0;
               end
            end else begin
               m_run[ch] = 0;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit a, input bit b, input bit en, input bit clr, input bit idx, input bit rst);
      @(negedge clock);
      if (k >= MAXC) begin
         $display("FAIL history_overflow at edge %0d: got %0d, expected %0d", k, k, MAXC - 1);
         $fatal(1, "history overflow");
      end
      reset_n       = ~rst;
      bus.quad_a    = a;
      bus.quad_b    = b;
      bus.enable    = en;
      bus.clear_req = clr;
      bus.index     = idx;
      h_rst[k] = rst; h_a[k] = a; h_b[k] = b; h_en[k] = en; h_clr[k] = clr; h_i[k] = idx;
      model_step(k);
      k++;
      started = 1'b1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(cur_a, cur_b, cur_en, 1'b0, cur_idx, 1'b0);
   endtask

   task automatic set_ab(input bit [1:0] ab, input int hold);
      cur_a = ab[1];
      cur_b = ab[0];
      run_cycles(hold);
   endtask

   // Monitor: one expected response per edge, compared 1 ns after the edge.
   initial begin : monitor
      exp_t e;
      int   edge_no = 0;
      forever begin
         @(posedge clock);
         #1;
         if (started) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", edge_no, 0, 1);
            end else begin
               e = exp_q.pop_front();
               check("control", edge_no, int'(bus.control), int'(e.control));
               check("error", edge_no, int'(bus.error), int'(e.error));
            end
            edge_no++;
         end
      end
   end

   initial begin : driver
      int pos;
      int hold;
      int r;
      bus.quad_a = 1'b0; bus.quad_b = 1'b0; bus.index = 1'b0;
      bus.enable = 1'b1; bus.clear_req = 1'b0;
      cur_a = 1'b0; cur_b = 1'b0; cur_en = 1'b1; cur_idx = 1'b0;

      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      run_cycles(5);

      // Forward then reverse full cycles, each level held 10 cycles.
      set_ab(2'b01, 10); set_ab(2'b11, 10); set_ab(2'b10, 10); set_ab(2'b00, 10);
      set_ab(2'b10, 10); set_ab(2'b11, 10); set_ab(2'b01, 10); set_ab(2'b00, 10);

      // Three-cycle glitch on A must be filtered out.
      cur_a = 1'b1; run_cycles(3);
      cur_a = 1'b0; run_cycles(10);

      // Illegal 01 -> 10 double change, then a one-cycle clear.
      set_ab(2'b01, 10);
      set_ab(2'b10, 12);
      cyc(cur_a, cur_b, cur_en, 1'b1, cur_idx, 1'b0);
      run_cycles(4);

      // Steps while disabled are dropped; only the step after re-enable pulses.
      cur_en = 1'b0;
      set_ab(2'b00, 10); set_ab(2'b01, 10);
      cur_en = 1'b1;
      set_ab(2'b11, 10);

      // Index pulse held 5 cycles during idle.
      cur_idx = 1'b1; run_cycles(5);
      cur_idx = 1'b0; run_cycles(8);

      // Randomised stepping, glitches, enables, clears and index activity.
      pos = gray_pos({cur_a, cur_b});
      while (k < 1400) begin
         r = $urandom_range(0, 9);
         if (r < 3)       pos = pos + 1;
         else if (r < 6)  pos = pos + 3;
         else if (r == 6) pos = pos + 2;
         else if (r == 7) begin
            cur_a = ~cur_a; run_cycles($urandom_range(1, 3)); cur_a = ~cur_a;
         end
         cur_a  = gray_ab(pos)[1];
         cur_b  = gray_ab(pos)[0];
         cur_en = ($urandom_range(0, 7) != 0);
         hold   = $urandom_range(1, 14);
         for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 19) == 0) cur_idx = ~cur_idx;
            cyc(cur_a, cur_b, cur_en, ($urandom_range(0, 24) == 0), cur_idx, 1'b0);
         end
      end

      // Reset in the middle of a pending debounce; the edge is withdrawn during reset.
      cur_en = 1'b1; cur_idx = 1'b0;
      set_ab(2'b00, 12);
      cur_a = 1'b1; run_cycles(3);
      cur_a = 1'b0;
      repeat (2) cyc(cur_a, cur_b, cur_en, 1'b0, cur_idx, 1'b1);
      run_cycles(15);

      @(posedge clock);
      #2;
      check("scoreboard_drained", k, exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_control_gen.md
Name: quad_control_gen

Overview:
- Upstream stage for the 16-bit up/down counter; converts raw quadrature encoder inputs (A/B, optional index) into that counter's 2-bit control code.
- Synchronises and debounces the inputs, then decodes Gray-code steps.
- Emits one-cycle up/down commands, holds otherwise, and issues reset on request.
- Control encoding: 2'b00 reset, 2'b01 count up, 2'b11 count down, 2'b10 hold.

Parameters:
SYNC_STAGES, 2, flip-flop stages per asynchronous input (legal 2..4)
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a filtered input changes (legal 1..255)

Ports:
clock  input  1  system clock, all logic on posedge
reset_n  input  1  synchronous, active-low reset
quad_a  input  1  encoder channel A, asynchronous
quad_b  input  1  encoder channel B, asynchronous
index  input  1  encoder index pulse, asynchronous (used only with INDEX_CLEAR_EN)
enable  input  1  1 = pass steps to control; 0 = force hold (tracking continues)
clear_req  input  1  synchronous request to reset downstream count and clear error
control  output  2  command to downstream counter (encoding above), registered
error  output  1  sticky flag: illegal A/B double transition seen

Behaviour:
- Reset (reset_n low at posedge):
  - control=2'b00, held for every reset cycle so the downstream counter clears.
  - error=0; synchroniser and filter flops load 0; debounce counters load 0; prev_ab=2'b00.
- First cycle after reset release: control=2'b10 unless a step or clear is decoded.
- Synchroniser: SYNC_STAGES-deep shift chain per input; only the last stage feeds logic.
- Debounce, independent per channel:
  - Counter increments while synced != filtered; resets to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, filtered takes the synced value and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches filtered.
- Decode: each cycle compare cur_ab={filt_a,filt_b} with prev_ab, then prev_ab<=cur_ab.
  - Forward sequence 00->01->11->10->00 gives an up step.
  - Reverse sequence 00->10->11->01->00 gives a down step.
  - No change gives no step.
  - Double change (00<->11, 01<->10): no step, error<=1.
- Output register, priority highest first:
  - clear_req=1: control=2'b00; error<=0 (unless a double change is detected in the same cycle, in which case error<=1).
  - Up step and enable=1: control=2'b01.
  - Down step and enable=1: control=2'b11.
  - Otherwise: control=2'b10.
- Pulse width: 2'b01 and 2'b11 last exactly one cycle per decoded step; back-to-back steps produce back-to-back pulses.
- Step dropping: a step coinciding with clear_req or enable=0 is dropped, not deferred; prev_ab still updates.
- Latency: a clean raw edge sampled at posedge N gives the control pulse registered at posedge N+SYNC_STAGES+DEBOUNCE_CYCLES+1 (7 at defaults).
- Maximum step rate: one step per DEBOUNCE_CYCLES+1 cycles; faster input is not guaranteed to decode.
- Error: sticky until clear_req or reset.
- Reset mid-operation: all pending debounce counts and the filtered state are discarded; no pulse is emitted for the aborted edge.

Optional Feature:
INDEX_CLEAR_EN
- Defined:
  - index passes through its own SYNC_STAGES synchroniser; no debounce.
  - A synced rising edge (0->1 between consecutive cycles) acts as clear_req for exactly one cycle: control=2'b00, error<=0, same priority as clear_req.
  - Latency: SYNC_STAGES+1 cycles.
- Undefined: index is ignored; no flops are instantiated for it.

Test Plan:
- reset_n=0 for 3 cycles, then 1 -> control=2'b00 during reset; 2'b10 on the first cycle after release; error=0.
- quad A/B stepped 00->01->11->10->00, each level held 10 cycles, enable=1 -> exactly four 2'b01 single-cycle pulses, each 7 cycles after its edge; 2'b10 otherwise.
- Reverse sequence 00->10->11->01->00 -> four 2'b11 pulses; then a 3-cycle glitch on quad_a -> no pulse, control stays 2'b10.
- Filtered AB 01->10 in one step -> no pulse, error=1 and held; clear_req for 1 cycle -> control=2'b00 that cycle, error=0 next cycle.
- enable=0 during two forward steps, then enable=1 and one more forward step -> only one 2'b01 pulse (after re-enable); no deferred pulses.
- With INDEX_CLEAR_EN: index 0->1 held 5 cycles during idle -> one 2'b00 cycle 3 cycles after the edge; without the macro -> control stays 2'b10.
